pixel_array_readout_fifo: RTL

Downstream stage of the pixel array: samples each readout beat (OUTPUT_BUS_PIXEL_WIDTH pixels on the DATA_OUT bus, strobed by DATA_OUT_CLK) in the SYSTEM_CLK domain. Tags every beat with start-of-frame, end-of-line and end-of-frame markers, and buffers it in a FIFO. Beats are presented to the image consumer over a valid/ready interface. Sticky flags report dropped beats and framing errors.

---
 rtl/pixel_array_readout_fifo_if.sv | 21 ++
 rtl/pixel_array_readout_fifo.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pixel_array_readout_fifo_if.sv
// Consumer-side stream of the pixel readout FIFO.
//   OUT_DATA          head-of-FIFO beat (zero while OUT_VALID is low)
//   OUT_SOF/EOL/EOF   position tags of the head beat
//   OUT_VALID         FIFO holds at least one beat
//   OUT_READY         consumer takes the head when OUT_VALID is high
// master = FIFO side, slave = image consumer side.
interface pixel_array_readout_fifo_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] OUT_DATA;
    logic              OUT_SOF;
    logic              OUT_EOL;
    logic              OUT_EOF;
    logic              OUT_VALID;
    logic              OUT_READY;

    modport master (output OUT_DATA, OUT_SOF, OUT_EOL, OUT_EOF, OUT_VALID,
                    input  OUT_READY);
    modport slave  (input  OUT_DATA, OUT_SOF, OUT_EOL, OUT_EOF, OUT_VALID,
                    output OUT_READY);
endinterface

// File: rtl/pixel_array_readout_fifo.sv
// Pixel array readout capture: detects beats on the DATA_OUT_CLK strobe,
// tags each beat with SOF/EOL/EOF from its array position and buffers it in
// a first-word-fall-through FIFO presented over a valid/ready stream.
//   SYSTEM_CLK    only clock
//   SYSTEM_RESET  synchronous active-high reset
//   FRAME_START   start-of-readout pulse (clears position counters)
//   DATA_OUT_CLK  beat strobe, same clock domain
//   DATA_IN       beat pixels
//   out_if        head-of-FIFO stream (data, tags, valid/ready)
//   FILL_LEVEL    occupied entries
//   OVERFLOW      sticky: beat dropped on a full FIFO
//   FRAME_ERROR   sticky: stray beat while idle or restart mid-frame
module pixel_array_readout_fifo #(
    parameter int WIDTH                  = 2,
    parameter int HEIGHT                 = 2,
    parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
    parameter int BIT_DEPTH              = 8,
    parameter int DEPTH                  = 8
) (
    input  logic                                        SYSTEM_CLK,
    input  logic                                        SYSTEM_RESET,
    input  logic                                        FRAME_START,
    input  logic                                        DATA_OUT_CLK,
    input  logic [OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH-1:0] DATA_IN,
    pixel_array_readout_fifo_if.master                  out_if,
    output logic [$clog2(DEPTH+1)-1:0]                  FILL_LEVEL,
    output logic                                        OVERFLOW,
    output logic                                        FRAME_ERROR
);
    localparam int DW  = OUTPUT_BUS_PIXEL_WIDTH * BIT_DEPTH;
    localparam int EW  = DW + 3;
    localparam int BPR = WIDTH / OUTPUT_BUS_PIXEL_WIDTH;
    localparam int BCW = (BPR > 1) ? $clog2(BPR) : 1;
    localparam int RCW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int AW  = $clog2(DEPTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    typedef struct packed {
        logic          sof;
        logic          eol;
        logic          eof;
        logic [DW-1:0] data;
    } entry_t;

    state_t         state_q, state_d;
    logic           clk_q;
    logic [BCW-1:0] beat_cnt, b_eff;
    logic [RCW-1:0] row_cnt, r_eff;
    logic [AW:0]    wr_ptr, rd_ptr;
    entry_t         mem [DEPTH];
    entry_t         wr_ent, head;
    logic           beat, accept, err_set;
    logic           empty, full, push, pop, drop;

    assign beat = DATA_OUT_CLK & ~clk_q;

    // A FRAME_START coinciding with a beat re-bases that beat to position 0.
    assign b_eff = FRAME_START ? '0 : beat_cnt;
    assign r_eff = FRAME_START ? '0 : row_cnt;

    assign wr_ent.sof  = (b_eff == '0) && (r_eff == '0);
    assign wr_ent.eol  = (b_eff == BCW'(BPR - 1));
    assign wr_ent.eof  = wr_ent.eol && (r_eff == RCW'(HEIGHT - 1));
    assign wr_ent.data = DATA_IN;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (FRAME_START) begin
                    state_d = ACTIVE;
                    accept  = beat;
                end else if (beat) begin
                    err_set = 1'b1;
                end
            end
            ACTIVE: begin
                accept  = beat;
                err_set = FRAME_START;
            end
            default: state_d = IDLE;
        endcase
        if (accept && wr_ent.eof)
            state_d = IDLE;
    end

    always_ff @(posedge SYSTEM_CLK) begin
        if (SYSTEM_RESET) state_q <= IDLE;
        else              state_q <= state_d;
    end

    // Counters advance on every accepted beat, dropped or not, so tags
    // keep tracking the physical array position.
    always_ff @(posedge SYSTEM_CLK) begin
        if (SYSTEM_RESET) begin
            clk_q    <= 1'b0;
            beat_cnt <= '0;
            row_cnt  <= '0;
        end else begin
            clk_q <= DATA_OUT_CLK;
            if (accept) begin
                if (wr_ent.eol) begin
                    beat_cnt <= '0;
                    row_cnt  <= wr_ent.eof ? '0 : r_eff + 1'b1;
                end else begin
                    beat_cnt <= b_eff + 1'b1;
                    row_cnt  <= r_eff;
                end
            end else if (FRAME_START) begin
                beat_cnt <= '0;
                row_cnt  <= '0;
            end
        end
    end

    // Pointer MSB differs only when the buffer has wrapped: full vs empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = ~empty & out_if.OUT_READY;
    assign push  = accept & (~full | pop);
    assign drop  = accept & full & ~pop;

    always_ff @(posedge SYSTEM_CLK) begin
        if (SYSTEM_RESET) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            OVERFLOW    <= 1'b0;
            FRAME_ERROR <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(push);
            rd_ptr <= rd_ptr + (AW+1)'(pop);
            if (drop)    OVERFLOW    <= 1'b1;
            if (err_set) FRAME_ERROR <= 1'b1;
        end
    end

    always_ff @(posedge SYSTEM_CLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_ent;
    end

    assign head       = mem[rd_ptr[AW-1:0]];
    assign FILL_LEVEL = wr_ptr - rd_ptr;

    assign out_if.OUT_VALID = ~empty;
    assign out_if.OUT_DATA  = empty ? '0 : head.data;
    assign out_if.OUT_SOF   = ~empty & head.sof;
    assign out_if.OUT_EOL   = ~empty & head.eol;
    assign out_if.OUT_EOF   = ~empty & head.eof;
endmodule
